// File: rtl/dpram_port_arbiter.sv
// Two-master round-robin arbiter in front of one port of the byte-enabled data RAM.
// A master can hold the grant across accesses for atomic read-modify-write.
module dpram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     m0_address,
    input  logic                      m0_read,
    input  logic                      m0_write,
    input  logic [DATA_WIDTH-1:0]     m0_writedata,
    input  logic [DATA_WIDTH/8-1:0]   m0_byteena,
    input  logic                      m0_lock,
    output logic                      m0_waitrequest,
    output logic [DATA_WIDTH-1:0]     m0_readdata,
    output logic                      m0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]     m1_address,
    input  logic                      m1_read,
    input  logic                      m1_write,
    input  logic [DATA_WIDTH-1:0]     m1_writedata,
    input  logic [DATA_WIDTH/8-1:0]   m1_byteena,
    input  logic                      m1_lock,
    output logic                      m1_waitrequest,
    output logic [DATA_WIDTH-1:0]     m1_readdata,
    output logic                      m1_readdatavalid,
    output logic [ADDR_WIDTH-1:0]     ram_address,
    output logic [DATA_WIDTH/8-1:0]   ram_byteena,
    output logic [DATA_WIDTH-1:0]     ram_wrdata,
    output logic                      ram_wren,
    input  logic [DATA_WIDTH-1:0]     ram_rddata
);

    typedef enum logic [1:0] {ST_RR, ST_LOCK0, ST_LOCK1} state_t;

    state_t                  state_q;
    logic                    last_grant_q;
    logic                    rd_valid_q;
    logic                    rd_owner_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wrdata_q;

    logic req0, req1, gnt0, gnt1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            ST_LOCK0: gnt0 = req0;
            ST_LOCK1: gnt1 = req1;
            default: begin
                // On contention the master that did not win last time goes first.
                if (req0 && req1) begin
                    gnt0 = last_grant_q;
                    gnt1 = ~last_grant_q;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

    always_comb begin
        ram_address = addr_q;
        ram_wrdata  = wrdata_q;
        ram_byteena = '0;
        ram_wren    = 1'b0;
        if (gnt0) begin
            ram_address = m0_address;
            ram_wrdata  = m0_writedata;
            ram_byteena = m0_byteena;
            ram_wren    = m0_write;
        end else if (gnt1) begin
            ram_address = m1_address;
            ram_wrdata  = m1_writedata;
            ram_byteena = m1_byteena;
            ram_wren    = m1_write;
        end
    end

    assign m0_waitrequest   = req0 & ~gnt0;
    assign m1_waitrequest   = req1 & ~gnt1;
    assign m0_readdata      = ram_rddata;
    assign m1_readdata      = ram_rddata;
    assign m0_readdatavalid = rd_valid_q & ~rd_owner_q;
    assign m1_readdatavalid = rd_valid_q &  rd_owner_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RR;
            last_grant_q <= 1'b1;
            rd_valid_q   <= 1'b0;
            rd_owner_q   <= 1'b0;
            addr_q       <= '0;
            wrdata_q     <= '0;
        end else begin
            if (gnt0 || gnt1) begin
                last_grant_q <= gnt1;
                addr_q       <= ram_address;
                wrdata_q     <= ram_wrdata;
            end
            // A combined read+write request is treated as a write only.
            rd_valid_q <= (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
            rd_owner_q <= gnt1;
            case (state_q)
                ST_LOCK0: if (!m0_lock) state_q <= ST_RR;
                ST_LOCK1: if (!m1_lock) state_q <= ST_RR;
                default: begin
                    if (gnt0 && m0_lock)      state_q <= ST_LOCK0;
                    else if (gnt1 && m1_lock) state_q <= ST_LOCK1;
                end
            endcase
        end
    end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
Shares one port of the byte-enabled dual-port data RAM between two Avalon-style masters, m0 (CPU data side) and m1 (loader/DMA side). Per-cycle round-robin arbitration, 1-cycle read latency with tagged read-data return, and a lock input that holds the grant for atomic read-modify-write sequences. The block sits directly in front of the RAM port.

Parameters:
DATA_WIDTH, 32, word width in bits (byte-enable width = DATA_WIDTH/8)
ADDR_WIDTH, 7, RAM word-address width

Ports:
clock  in  1  single clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
mN_address  in  ADDR_WIDTH  master N word address (N = 0,1; every mN_ port is duplicated per master)
mN_read  in  1  read request
mN_write  in  1  write request
mN_writedata  in  DATA_WIDTH  write data
mN_byteena  in  DATA_WIDTH/8  write byte enables
mN_lock  in  1  keep grant after this access
mN_waitrequest  out  1  request not accepted this cycle
mN_readdata  out  DATA_WIDTH  read data
mN_readdatavalid  out  1  readdata valid this cycle
ram_address  out  ADDR_WIDTH  to RAM port address
ram_byteena  out  DATA_WIDTH/8  to RAM port byte enables
ram_wrdata  out  DATA_WIDTH  to RAM port write data
ram_wren  out  1  to RAM port write enable
ram_rddata  in  DATA_WIDTH  from RAM port; valid 1 cycle after address

Behaviour:
- reqN = mN_read | mN_write. Combinational grant each cycle, one master at most.
- State machine (registered): RR (round-robin), LOCK0, LOCK1. Reset -> RR.
- Priority register last_grant; reset value 1, so m0 wins the first contention.
- RR state:
  - only one master requests -> that master is granted;
  - both request -> grant the master that is not last_grant;
  - none request -> no grant, RAM outputs idle.
  - last_grant updates on every grant.
- LOCKn state: only master n can be granted; the other master waits even if n is idle.
- Lock transitions:
  - RR -> LOCKn when master n is granted with mN_lock=1.
  - LOCKn -> RR on the first cycle mN_lock=0 (with or without a request). The unlocking access, if any, is still granted to n.
- mN_waitrequest = reqN & ~grantN. A master holds address/data/controls stable while waitrequest=1.
- Granted cycle drives ram_address, ram_byteena, ram_wrdata from the winner. ram_wren = granted & mN_write.
- Ungranted cycle: ram_wren=0, ram_byteena=0; address/data are don't-care but held at the last value.
- Read path:
  - a granted read sets rd_valid<=1 and rd_owner<=N (registers, reset 0).
  - Next cycle: mN_readdatavalid = rd_valid & (rd_owner==N). Both mN_readdata are driven from ram_rddata.
  - Latency is exactly 1 cycle from the accepted read to readdatavalid. Back-to-back reads give a valid every cycle.
- read & write both asserted in one request: the write is performed, no readdatavalid is produced.
- Read after write to the same address from either master: the RAM returns written data on the next access cycle. Same-cycle collision with the RAM's other port is outside this block: old data is returned there.
- Reset mid-operation: state -> RR, last_grant=1, rd_valid=0. Any pending readdatavalid is dropped. Waitrequest follows the combinational rule immediately after reset deasserts.
- Reset values of registered outputs: mN_readdatavalid=0. Combinational outputs follow the request inputs.

Test Plan:
- Single master: m0 writes 0xDEADBEEF (byteena 4'hF) to addr 5, then reads addr 5 -> m0_waitrequest=0 both cycles; m0_readdatavalid exactly 1 cycle after the read grant with m0_readdata=0xDEADBEEF; m1_readdatavalid stays 0.
- Contention: m0 and m1 both read continuously from reset -> grants alternate m0,m1,m0,...; each master's waitrequest=1 on alternate cycles; each readdatavalid is routed to the correct owner with no loss.
- Byte enable: m1 writes 0x11223344 to addr 9, then writes 0xAABBCCDD with byteena 4'b0101, then reads -> 0x11BB33DD.
- Lock: m0 issues a locked read of addr 3 followed by an unlocked write, while m1 requests throughout -> m1_waitrequest=1 for both m0 cycles, then m1 is granted. The lock holds for one idle m0 cycle inserted between the two accesses.
- Reset mid-read: m1 read is granted, rst is pulsed in the following cycle -> m1_readdatavalid=0; after reset both request and m0 is granted first.
- Read+write conflict: m0_read=m0_write=1, addr 7, data 0x5 -> RAM word 7 = 0x5; no m0_readdatavalid pulse.
